// File: rtl/dma_clk_gate_ctrl.sv
// Idle-detect controller for the DMA clock gate enable: gates the engine clock
// after a programmable idle window behind a sleep_req/sleep_ack handshake.
module dma_clk_gate_ctrl #(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gate_en,
  input  logic             force_on,
  input  logic             act_req,
  input  logic             busy,
  input  logic             sleep_ack,
  output logic             clk_en,
  output logic             sleep_req,
  output logic             gated,
  output logic             wake_done,
  output logic [CNT_W-1:0] gate_cnt
);

  localparam int unsigned IDLE_W = (IDLE_CYCLES + 1 > 1) ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam int unsigned WAKE_W = (WAKE_CYCLES + 1 > 1) ? $clog2(WAKE_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_IDLE_CNT  = 3'd1,
    ST_SLEEP_REQ = 3'd2,
    ST_GATED     = 3'd3,
    ST_WAKE      = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [WAKE_W-1:0]  wake_cnt_q, wake_cnt_d;
  logic [CNT_W-1:0]   gate_cnt_q, gate_cnt_d;
  logic               clk_en_q, clk_en_d;
  logic               sleep_req_q, sleep_req_d;
  logic               gated_q, gated_d;
  logic               wake_done_q, wake_done_d;

  logic activity;
  logic wake_act;

  // busy comes from the gated domain and is stale while the clock is stopped
  assign activity = act_req | busy | force_on | ~gate_en;
  assign wake_act = act_req | force_on | ~gate_en;

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    wake_cnt_d  = wake_cnt_q;
    gate_cnt_d  = gate_cnt_q;
    wake_done_d = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (!activity) begin
          state_d    = ST_IDLE_CNT;
          idle_cnt_d = '0;
        end
      end

      ST_IDLE_CNT: begin
        if (activity) begin
          state_d    = ST_RUN;
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_W'(IDLE_CYCLES - 1)) begin
          state_d    = ST_SLEEP_REQ;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end

      ST_SLEEP_REQ: begin
        // Activity wins over a same-cycle acknowledge
        if (activity) begin
          state_d = ST_RUN;
        end else if (sleep_ack) begin
          state_d = ST_GATED;
          if (gate_cnt_q != {CNT_W{1'b1}}) begin
            gate_cnt_d = gate_cnt_q + CNT_W'(1);
          end
        end
      end

      ST_GATED: begin
        if (wake_act) begin
          state_d    = ST_WAKE;
          wake_cnt_d = '0;
        end
      end

      ST_WAKE: begin
        if (wake_cnt_q == WAKE_W'(WAKE_CYCLES - 1)) begin
          state_d     = ST_RUN;
          wake_cnt_d  = '0;
          wake_done_d = 1'b1;
        end else begin
          wake_cnt_d = wake_cnt_q + WAKE_W'(1);
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    clk_en_d    = (state_d != ST_GATED);
    sleep_req_d = (state_d == ST_SLEEP_REQ);
    gated_d     = (state_d == ST_GATED);
  end

  // State and output registers; clock stays enabled through reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      idle_cnt_q  <= '0;
      wake_cnt_q  <= '0;
      gate_cnt_q  <= '0;
      clk_en_q    <= 1'b1;
      sleep_req_q <= 1'b0;
      gated_q     <= 1'b0;
      wake_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      wake_cnt_q  <= wake_cnt_d;
      gate_cnt_q  <= gate_cnt_d;
      clk_en_q    <= clk_en_d;
      sleep_req_q <= sleep_req_d;
      gated_q     <= gated_d;
      wake_done_q <= wake_done_d;
    end
  end

  assign clk_en    = clk_en_q;
  assign sleep_req = sleep_req_q;
  assign gated     = gated_q;
  assign wake_done = wake_done_q;
  assign gate_cnt  = gate_cnt_q;

endmodule

// File: tb/tb_dma_clk_gate_ctrl.sv
// Directed bench for dma_clk_gate_ctrl with IDLE_CYCLES=4, WAKE_CYCLES=2, CNT_W=2.
module tb_dma_clk_gate_ctrl;

  logic       clk;
  logic       rst;
  logic       gate_en;
  logic       force_on;
  logic       act_req;
  logic       busy;
  logic       sleep_ack;
  logic       clk_en;
  logic       sleep_req;
  logic       gated;
  logic       wake_done;
  logic [1:0] gate_cnt;

  int errors = 0;
  int checks = 0;

  dma_clk_gate_ctrl #(
    .IDLE_CYCLES(4),
    .WAKE_CYCLES(2),
    .CNT_W      (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .gate_en  (gate_en),
    .force_on (force_on),
    .act_req  (act_req),
    .busy     (busy),
    .sleep_ack(sleep_ack),
    .clk_en   (clk_en),
    .sleep_req(sleep_req),
    .gated    (gated),
    .wake_done(wake_done),
    .gate_cnt (gate_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: outputs are observed 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full gate/wake round starting from RUN or IDLE_CNT
  task automatic gate_round(input logic [1:0] exp_cnt);
    act_req = 1'b1;
    tick();
    act_req = 1'b0;
    ticks(5);
    chk("round_sleep_req", 32'(sleep_req), 32'd1);
    sleep_ack = 1'b1;
    tick();
    sleep_ack = 1'b0;
    chk("round_gated", 32'(gated), 32'd1);
    chk("round_gate_cnt", 32'(gate_cnt), 32'(exp_cnt));
    act_req = 1'b1;
    tick();
    act_req = 1'b0;
    ticks(2);
    chk("round_wake_done", 32'(wake_done), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    gate_en   = 1'b1;
    force_on  = 1'b0;
    act_req   = 1'b0;
    busy      = 1'b0;
    sleep_ack = 1'b0;

    // Reset held 3 cycles
    ticks(3);
    rst = 1'b0;
    chk("rst_clk_en", 32'(clk_en), 32'd1);
    chk("rst_sleep_req", 32'(sleep_req), 32'd0);
    chk("rst_gated", 32'(gated), 32'd0);
    chk("rst_wake_done", 32'(wake_done), 32'd0);
    chk("rst_gate_cnt", 32'(gate_cnt), 32'd0);

    // Idle from cycle 0: sleep_req at cycle 5, ack at 7, gated at 8
    ticks(4);
    chk("idle_c4_sleep_req", 32'(sleep_req), 32'd0);
    tick();
    chk("idle_c5_sleep_req", 32'(sleep_req), 32'd1);
    chk("idle_c5_clk_en", 32'(clk_en), 32'd1);
    ticks(2);
    chk("idle_c7_clk_en", 32'(clk_en), 32'd1);
    sleep_ack = 1'b1;
    tick();
    sleep_ack = 1'b0;
    chk("gate_c8_clk_en", 32'(clk_en), 32'd0);
    chk("gate_c8_gated", 32'(gated), 32'd1);
    chk("gate_c8_sleep_req", 32'(sleep_req), 32'd0);
    chk("gate_c8_gate_cnt", 32'(gate_cnt), 32'd1);

    // Stale busy is ignored while gated
    busy = 1'b1;
    tick();
    busy = 1'b0;
    chk("gated_busy_clk_en", 32'(clk_en), 32'd0);

    // Wake: act_req at n -> clk_en at n+1, wake_done at n+3 only
    act_req = 1'b1;
    tick();
    act_req = 1'b0;
    chk("wake_n1_clk_en", 32'(clk_en), 32'd1);
    chk("wake_n1_gated", 32'(gated), 32'd0);
    chk("wake_n1_done", 32'(wake_done), 32'd0);
    tick();
    chk("wake_n2_done", 32'(wake_done), 32'd0);
    tick();
    chk("wake_n3_done", 32'(wake_done), 32'd1);
    tick();
    chk("wake_n4_done", 32'(wake_done), 32'd0);
    chk("wake_gate_cnt", 32'(gate_cnt), 32'd1);

    // Activity pulse in IDLE_CNT restarts the idle window
    act_req = 1'b1;
    tick();
    act_req = 1'b0;
    ticks(3);
    act_req = 1'b1;
    tick();
    act_req = 1'b0;
    chk("restart_c4_sleep_req", 32'(sleep_req), 32'd0);
    ticks(4);
    chk("restart_c8_sleep_req", 32'(sleep_req), 32'd0);
    tick();
    chk("restart_c9_sleep_req", 32'(sleep_req), 32'd1);

    // Same-cycle ack and activity: activity wins
    sleep_ack = 1'b1;
    act_req   = 1'b1;
    tick();
    sleep_ack = 1'b0;
    act_req   = 1'b0;
    chk("prio_sleep_req", 32'(sleep_req), 32'd0);
    chk("prio_clk_en", 32'(clk_en), 32'd1);
    chk("prio_gated", 32'(gated), 32'd0);
    chk("prio_gate_cnt", 32'(gate_cnt), 32'd1);
    tick();
    chk("prio_after_clk_en", 32'(clk_en), 32'd1);

    // Saturating gate counter
    gate_round(2'd2);
    gate_round(2'd3);
    gate_round(2'd3);
    gate_round(2'd3);

    // force_on keeps the clock running despite idle and ack
    force_on  = 1'b1;
    sleep_ack = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("force_on_clk_en", 32'(clk_en), 32'd1);
      chk("force_on_sleep_req", 32'(sleep_req), 32'd0);
    end

    // gate_en=0 likewise never gates
    force_on = 1'b0;
    gate_en  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("gate_dis_clk_en", 32'(clk_en), 32'd1);
      chk("gate_dis_sleep_req", 32'(sleep_req), 32'd0);
    end
    sleep_ack = 1'b0;
    gate_en   = 1'b1;

    // Reach GATED again, then reset there
    ticks(5);
    chk("pre_rst_sleep_req", 32'(sleep_req), 32'd1);
    sleep_ack = 1'b1;
    tick();
    sleep_ack = 1'b0;
    chk("pre_rst_gated", 32'(gated), 32'd1);
    chk("pre_rst_gate_cnt", 32'(gate_cnt), 32'd3);
    rst = 1'b1;
    tick();
    chk("rst_gated_clk_en", 32'(clk_en), 32'd1);
    chk("rst_gated_gated", 32'(gated), 32'd0);
    chk("rst_gated_gate_cnt", 32'(gate_cnt), 32'd0);
    chk("rst_gated_sleep_req", 32'(sleep_req), 32'd0);
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
